// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the chunk-serial adder/subtractor.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int numChunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Counter sized to hold 0..N so the width is never zero, even when N = 1.
  function automatic int cntWidth(input int width, input int chunk);
    return $clog2(numChunks(width, chunk) + 1);
  endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational CHUNK-bit ripple adder; also reports the carry into its MSB
// so the caller can derive signed overflow on the final chunk.
module chunk_add #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             carryMsb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[CHUNK];
  assign carryMsb = c[CHUNK-1];

endmodule

// File: rtl/serial_add_sub.sv
// Chunk-serial add/subtract: CHUNK bits per clock over WIDTH/CHUNK cycles,
// results published only when the operation completes.
module serial_add_sub
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbgState
);

  localparam int N  = numChunks(WIDTH, CHUNK);
  localparam int CW = cntWidth(WIDTH, CHUNK);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH % CHUNK != 0) begin : gBadChunk
    $error("serial_add_sub: WIDTH must be a multiple of CHUNK");
  end

  state_e           state;
  state_e           stateNext;
  logic             accept;
  logic             lastChunk;
  logic [WIDTH-1:0] aSh;
  logic [WIDTH-1:0] bSh;
  logic [WIDTH-1:0] resSh;
  logic [WIDTH-1:0] resNext;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] chunkSum;
  logic             chunkCout;
  logic             chunkMsb;

  // Handshake: start is a request, honoured only on a cycle where the block
  // is IDLE or DONE; a start seen while RUN is dropped and never queued.
  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign lastChunk = (cnt == LAST);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign dbgState  = state;

  chunk_add #(.CHUNK(CHUNK)) uChunk (
    .a        (aSh[CHUNK-1:0]),
    .b        (bSh[CHUNK-1:0]),
    .cin      (carry),
    .sum      (chunkSum),
    .cout     (chunkCout),
    .carryMsb (chunkMsb)
  );

  // New chunk enters at the MSB end so the result is aligned after N shifts.
  assign resNext = (resSh >> CHUNK) | (WIDTH'(chunkSum) << (WIDTH - CHUNK));

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = RUN;
      RUN:     if (lastChunk) stateNext = DONE;
      DONE:    stateNext = accept ? RUN : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aSh   <= '0;
      bSh   <= '0;
      resSh <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      aSh   <= a;
      bSh   <= b ^ {WIDTH{sub}};
      carry <= sub | cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      aSh   <= aSh >> CHUNK;
      bSh   <= bSh >> CHUNK;
      resSh <= resNext;
      carry <= chunkCout;
      cnt   <= cnt + 1'b1;
      if (lastChunk) begin
        sum  <= resNext;
        cout <= chunkCout;
        ovf  <= chunkCout ^ chunkMsb;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: 32/4 directed vectors plus 8-bit chunk sweep,
// scoreboard queues drained by negedge monitors.
module tb_serial_add_sub;

  localparam int N32 = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 32-bit DUT
  logic        start32, sub32, cin32;
  logic [31:0] a32, b32;
  logic        busy32, done32, cout32, ovf32;
  logic [31:0] sum32;
  logic [1:0]  dbg32;

  serial_add_sub #(.WIDTH(32), .CHUNK(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .sub(sub32), .a(a32), .b(b32),
    .cin(cin32), .busy(busy32), .done(done32), .sum(sum32), .cout(cout32),
    .ovf(ovf32), .dbgState(dbg32)
  );

  // 8-bit DUTs with CHUNK = 1, 2, 8
  logic       [2:0] start8;
  logic             sub8, cin8;
  logic       [7:0] a8, b8;
  logic       [2:0] busy8, done8, cout8, ovf8;
  logic       [7:0] sum8[3];
  logic       [1:0] dbg8[3];

  for (genvar k = 0; k < 3; k++) begin : gSweep
    serial_add_sub #(.WIDTH(8), .CHUNK((k == 0) ? 1 : ((k == 1) ? 2 : 8))) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8[k]), .sub(sub8), .a(a8), .b(b8),
      .cin(cin8), .busy(busy8[k]), .done(done8[k]), .sum(sum8[k]),
      .cout(cout8[k]), .ovf(ovf8[k]), .dbgState(dbg8[k])
    );
  end

  // Expected entries: {done cycle, cout, ovf, sum}
  logic [65:0] exp32_q[$];
  logic [41:0] exp8_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // 32-bit monitor
  logic        prevRstLow = 1'b0;
  logic        armed = 1'b0;
  logic [31:0] holdSum = '0;

  always @(negedge clk) begin
    logic [65:0] e;
    if (prevRstLow) begin
      check("rst_busy", busy32, 0);
      check("rst_done", done32, 0);
      check("rst_sum", sum32, 0);
      check("rst_cout", cout32, 0);
      check("rst_ovf", ovf32, 0);
      check("rst_state", dbg32, 0);
      exp32_q.delete();
      holdSum = '0;
      armed = 1'b1;
    end else if (armed) begin
      if (done32) begin
        if (exp32_q.size() == 0) begin
          check("unexpected_done32", 1, 0);
        end else begin
          e = exp32_q.pop_front();
          check("sum32", sum32, e[31:0]);
          check("ovf32", ovf32, e[32]);
          check("cout32", cout32, e[33]);
          check("latency32", cyc, e[65:34]);
        end
        holdSum = sum32;
      end else begin
        check("hold32", sum32, holdSum);
      end
    end
    prevRstLow = !rst_n;
  end

  // 8-bit monitor (only one sweep DUT is active at a time)
  always @(negedge clk) begin
    logic [41:0] e;
    for (int k = 0; k < 3; k++) begin
      if (done8[k] === 1'b1) begin
        if (exp8_q.size() == 0) begin
          check("unexpected_done8", k, 99);
        end else begin
          e = exp8_q.pop_front();
          check("sum8", sum8[k], e[7:0]);
          check("ovf8", ovf8[k], e[8]);
          check("cout8", cout8[k], e[9]);
          check("latency8", cyc, e[41:10]);
        end
      end
    end
  end

  task automatic wait_done32();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done32) seen = 1'b1;
    end
    if (!seen) check("timeout32", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic op32(input logic s, input logic [31:0] x, input logic [31:0] y,
                      input logic ci, input logic [31:0] es, input logic ec,
                      input logic eo);
    sub32 = s; a32 = x; b32 = y; cin32 = ci; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    exp32_q.push_back({32'(cyc + N32), ec, eo, es});
    wait_done32();
  endtask

  task automatic op8(input int k, input int n, input logic s, input logic [7:0] x,
                     input logic [7:0] y, input logic ci);
    logic [8:0] r;
    logic       eo, ec;
    bit         seen = 1'b0;
    if (s) begin
      r  = {1'b0, x - y};
      ec = (x >= y);
      eo = (x[7] != y[7]) && (r[7] != x[7]);
    end else begin
      r  = {1'b0, x} + {1'b0, y} + {8'd0, ci};
      ec = r[8];
      eo = (x[7] == y[7]) && (r[7] != x[7]);
    end
    sub8 = s; a8 = x; b8 = y; cin8 = ci; start8[k] = 1'b1;
    @(posedge clk); #1;
    start8[k] = 1'b0;
    exp8_q.push_back({32'(cyc + n), ec, eo, r[7:0]});
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done8[k]) seen = 1'b1;
    end
    if (!seen) check("timeout8", k, 99);
    @(posedge clk); #1;
  endtask

  logic [7:0] vals[12] = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81,
                           8'hFE, 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0};
  int         nk[3] = '{8, 4, 1};

  initial begin
    rst_n = 1'b0;
    start32 = 1'b0; sub32 = 1'b0; cin32 = 1'b0; a32 = '0; b32 = '0;
    start8 = '0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // directed 32-bit vectors
    op32(0, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 1, 0);
    op32(0, 32'h7FFFFFFF, 32'h00000001, 0, 32'h80000000, 0, 1);
    op32(1, 32'h00000005, 32'h00000007, 0, 32'hFFFFFFFE, 0, 0);
    op32(1, 32'h80000000, 32'h00000001, 0, 32'h7FFFFFFF, 1, 1);
    op32(0, 32'h12345678, 32'h11111111, 1, 32'h2345678A, 0, 0);
    op32(1, 32'h00000007, 32'h00000005, 1, 32'h00000002, 1, 0);
    op32(0, 32'h80000000, 32'h80000000, 0, 32'h00000000, 1, 1);
    op32(1, 32'h00000000, 32'h00000000, 0, 32'h00000000, 1, 0);

    // start during RUN is ignored
    sub32 = 1; a32 = 32'd5; b32 = 32'd7; cin32 = 0; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    exp32_q.push_back({32'(cyc + N32), 1'b0, 1'b0, 32'hFFFFFFFE});
    repeat (3) @(posedge clk);
    #1 sub32 = 0; a32 = 32'd1; b32 = 32'd1; start32 = 1'b1;
    @(posedge clk); #1 start32 = 1'b0;
    wait_done32();
    repeat (12) @(posedge clk);
    #1;

    // reset mid-RUN aborts, start during reset is ignored
    sub32 = 0; a32 = 32'h11111111; b32 = 32'h22222222; cin32 = 0; start32 = 1'b1;
    @(posedge clk); #1 start32 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0; start32 = 1'b1; a32 = 32'h3; b32 = 32'h4;
    @(posedge clk); #1 rst_n = 1'b1; start32 = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    op32(0, 32'h00000010, 32'h00000020, 1, 32'h00000031, 0, 0);

    // start held high: three back-to-back operations
    sub32 = 0; a32 = 32'd1; b32 = 32'd2; cin32 = 0; start32 = 1'b1;
    @(posedge clk); #1;
    exp32_q.push_back({32'(cyc + N32), 1'b0, 1'b0, 32'h00000003});
    sub32 = 1; a32 = 32'd10; b32 = 32'd3; cin32 = 0;
    repeat (N32 + 1) @(posedge clk);
    #1;
    exp32_q.push_back({32'(cyc + N32), 1'b1, 1'b0, 32'h00000007});
    sub32 = 0; a32 = 32'hFFFFFFFF; b32 = 32'hFFFFFFFF; cin32 = 1;
    repeat (N32 + 1) @(posedge clk);
    #1;
    exp32_q.push_back({32'(cyc + N32), 1'b1, 1'b0, 32'hFFFFFFFF});
    start32 = 1'b0;
    wait_done32();
    repeat (4) @(posedge clk);
    #1;

    // 8-bit sweep over corner operands for each CHUNK
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 12; i++)
        for (int j = 0; j < 12; j++)
          for (int m = 0; m < 4; m++)
            op8(k, nk[k], m[1], vals[i], vals[j], m[0]);

    repeat (5) @(posedge clk);
    check("exp32_q_empty", exp32_q.size(), 0);
    check("exp8_q_empty", exp8_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter CHUNK, default 4, bits processed per clock; WIDTH % CHUNK SHALL be 0, checked at elaboration.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request a new operation; sampled only when accepted (REQ-011).
REQ-006 sub  input  1  0 = a+b+cin, 1 = a-b (cin ignored).
REQ-007 a  input  WIDTH  operand A, two's complement or unsigned.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in for add mode.
REQ-010 busy  output  1  high while an operation is in progress; done  output  1  one-cycle completion pulse; sum  output  WIDTH  result; cout  output  1  carry-out (sub: 1 = no borrow); ovf  output  1  signed overflow.

Function
REQ-011 FSM states IDLE, RUN, DONE; start SHALL be accepted only in IDLE or DONE; start in RUN SHALL be ignored with no effect.
REQ-012 On acceptance: capture a, b XOR {WIDTH{sub}}, initial carry = sub ? 1 : cin; clear chunk counter; go to RUN.
REQ-013 RUN: each cycle add lowest CHUNK bits of both operand shift registers plus carry; shift operands right by CHUNK; shift chunk result into MSB end of result register; update carry.
REQ-014 RUN SHALL last exactly N = WIDTH/CHUNK cycles; after the Nth chunk go to DONE.
REQ-015 Latency: done SHALL be high in the cycle beginning N clock edges after the edge that accepted start, for exactly one cycle.
REQ-016 busy = 1 exactly in RUN; done = 1 exactly in DONE.
REQ-017 cout = final carry out of bit WIDTH-1; ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, computed on the last chunk.
REQ-018 sum, cout, ovf SHALL update only at the transition into DONE and hold until the next transition into DONE or reset; intermediate chunk results SHALL NOT appear on sum.
REQ-019 DONE without start -> IDLE; DONE with start -> RUN (back-to-back, throughput one op per N+1 cycles).
REQ-020 Inputs a, b, sub, cin SHALL be don't-care except on the acceptance cycle.
REQ-021 CHUNK = WIDTH SHALL give N = 1 (done one cycle after acceptance); CHUNK = 1 SHALL give a pure bit-serial adder.

Reset
REQ-022 rst_n = 0 at a rising edge SHALL force IDLE, busy = 0, done = 0, sum = 0, cout = 0, ovf = 0, counter and carry = 0.
REQ-023 Reset in RUN or DONE SHALL abort the operation with no done pulse; start sampled in the same cycle as reset SHALL be ignored.

Structure
REQ-024 Package serial_add_pkg SHALL hold the state typedef (IDLE/RUN/DONE) and the function computing N and counter width ($clog2(N+1)).
REQ-025 One sub-module chunk_add (combinational CHUNK-bit ripple adder; outputs sum, carry out, carry into MSB) SHALL be instantiated once; all registers live in serial_add_sub.

Verification
REQ-026 WIDTH=32, CHUNK=4: add 0xFFFFFFFF + 0x00000001, cin=0 -> done 8 cycles after start; sum 0x00000000, cout 1, ovf 0.
REQ-027 add 0x7FFFFFFF + 0x00000001 -> sum 0x80000000, cout 0, ovf 1; sub 5 - 7 -> sum 0xFFFFFFFE, cout 0, ovf 0; sub 0x80000000 - 1 -> sum 0x7FFFFFFF, ovf 1.
REQ-028 start pulsed during RUN with different operands -> ignored; first result unchanged, exactly one done pulse.
REQ-029 rst_n low for one cycle mid-RUN -> next cycle IDLE, all outputs 0, no done; new start then completes normally.
REQ-030 start held high continuously, 3 operations -> done every 9 cycles, results correct in order; sum stable between pulses.
REQ-031 Parameter sweep WIDTH=8 with CHUNK=1, 2, 8: exhaustive a, b, sub, cin vs. reference model; latency = WIDTH/CHUNK.
